hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Parametrised hazard and forwarding controller for the in-order RISC-V pipeline. It supports a configurable number of memory stages (M1..Mk) between Execute and WriteBack.
- Tracks destination-register state for every in-flight stage.
- Generates ALU operand forwarding selects, load-use stalls, branch flushes and a global data-memory wait freeze.
- Keeps saturating stall and flush event counters.

It sits beside the datapath and drives the enable and clear inputs of the IF/ID, ID/EX and downstream pipeline registers.

Parameters:
- REG_AW, 5, register address width.
- MEM_LAT, 1, number of memory stages k (1..4); load data is usable only from WriteBack.
- CNT_W, 16, width of the performance counters.
- FWD_W (localparam), $clog2(MEM_LAT+2), width of the forward-select fields.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- dec_valid  in  1  decode stage holds a real instruction
- dec_rs1, dec_rs2  in  REG_AW  decode source registers
- dec_use_rs1, dec_use_rs2  in  1  each source is actually read
- dec_rd  in  REG_AW  decode destination register
- dec_regwrite  in  1  decode instruction writes rd
- dec_is_load  in  1  decode instruction is a load
- branch_taken_e  in  1  branch or jump in E resolved taken (PCSrcE)
- mem_wait  in  1  data memory not ready; freeze the whole pipeline
- stall_f, stall_d  out  1  hold PC / hold IF/ID
- stall_all  out  1  hold every pipeline register
- flush_d, flush_e  out  1  clear IF/ID / insert bubble into ID/EX
- fwd_a_e, fwd_b_e  out  FWD_W  E operand select: 0 = register file, i = M_i (1..k), k+1 = W
- stall_cnt, flush_cnt  out  CNT_W  event counters

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high.
- On reset:
  - all stage valid bits = 0 and E source fields = 0.
  - counters = 0.
  - While rst is high: stall_* = 0, flush_d = flush_e = 1, fwd_* = 0.
- Tracking state:
  - Stages E, M1..Mk, W each hold {valid, rd, regwrite, is_load}.
  - E additionally holds {rs1, rs2, use_rs1, use_rs2}.
  - A stage is a producer if valid & regwrite & rd != 0.
- Forwarding (combinational from state):
  - For an E operand that is used and nonzero, select the youngest producer whose rd matches. Priority is M1 > M2 > ... > Mk > W.
  - A load in any M stage is never a forward source; skip it and continue down the priority list.
  - No match: 0.
  - Register x0 is never forwarded.
- Load-use stall (lu):
  - Asserted when dec_valid is set and a used, nonzero decode source matches rd of a valid load in E or M1..M_{k-1}.
  - With k = 1 this is E only, giving one bubble. In general, up to k bubbles.
- Output priority:
  - If mem_wait: stall_all = stall_f = stall_d = 1, flush_d = flush_e = 0. State holds.
  - Else if branch_taken_e: flush_d = flush_e = 1, stall_f = stall_d = 0. Branch wins over lu.
  - Else if lu: stall_f = stall_d = 1, flush_e = 1.
  - Otherwise all 0.
- Branch under mem_wait: the branch stays in E and is re-evaluated when mem_wait drops.
- State update each cycle when not mem_wait:
  - W <= Mk; M_i <= M_{i-1}; M1 <= E.
  - E <= bubble (valid = 0) if flush_e, else the decode fields (valid = dec_valid).
- Counters:
  - stall_cnt increments on any cycle with stall_d = 1.
  - flush_cnt increments on any cycle with branch_taken_e = 1 and mem_wait = 0.
  - Both saturate at all-ones; no wrap.
- Reset mid-operation: all in-flight state is discarded in the same cycle and counters clear.

Decomposition:
- Shared package hazard_pkg:
  - stage_info_t struct {valid, rd, regwrite, is_load}.
  - Forward-select encoding constants FWD_RF = 0 and FWD_W_SEL(k) = k+1.
- Sub-module fwd_sel: one instance per operand. It is a purely combinational priority match over the stage array.

Test Plan:
- MEM_LAT=1: add x5 in E, then sub using x5 in D the next cycle -> fwd_a_e = 1 (M1), no stall.
- MEM_LAT=1: lw x6, then add x7,x6,x1 -> one cycle with stall_f = stall_d = flush_e = 1; the next cycle fwd_a_e = 2 (W).
- MEM_LAT=2: lw x6 followed by a dependent instruction -> exactly two stall cycles; stall_cnt advances by 2.
- branch_taken_e = 1 together with a load-use match -> flush_d = flush_e = 1, stall_f = 0; flush_cnt + 1.
- mem_wait held 3 cycles with a producer in M1 -> stall_all = 1 for those cycles, fwd values unchanged; the pipeline advances once afterwards.
- Writes to x0 in M1 and W with consumer rs1 = 0 -> fwd_a_e = 0 and no stall. Separately, assert rst mid-stream -> all outputs reset next cycle and counters = 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/forwarding controller.
package hazard_pkg;

    // Stage rd fields are stored at this fixed width; REG_AW must not exceed it.
    localparam int RD_MAX_W = 8;

    // Forward-select code for "take the operand from the register file".
    localparam int FWD_RF = 0;

    // Per-stage tracking record for E, M1..Mk and W.
    typedef struct packed {
        logic                valid;
        logic [RD_MAX_W-1:0] rd;
        logic                regwrite;
        logic                is_load;
    } stage_info_t;

    // Forward-select code for the WriteBack stage with k memory stages.
    function automatic int FWD_W_SEL(input int k);
        return k + 1;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode-side inputs and pipeline-control outputs of the hazard controller.
interface hazard_ctrl_if #(
    parameter int REG_AW  = 5,
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 16
);
    localparam int FWD_W = $clog2(MEM_LAT + 2);

    logic              dec_valid;
    logic [REG_AW-1:0] dec_rs1;
    logic [REG_AW-1:0] dec_rs2;
    logic              dec_use_rs1;
    logic              dec_use_rs2;
    logic [REG_AW-1:0] dec_rd;
    logic              dec_regwrite;
    logic              dec_is_load;
    logic              branch_taken_e;
    logic              mem_wait;

    logic              stall_f;
    logic              stall_d;
    logic              stall_all;
    logic              flush_d;
    logic              flush_e;
    logic [FWD_W-1:0]  fwd_a_e;
    logic [FWD_W-1:0]  fwd_b_e;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    // Datapath side: presents decode info, consumes stall/flush/forward controls.
    modport master (
        output dec_valid, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2,
               dec_rd, dec_regwrite, dec_is_load, branch_taken_e, mem_wait,
        input  stall_f, stall_d, stall_all, flush_d, flush_e,
               fwd_a_e, fwd_b_e, stall_cnt, flush_cnt
    );

    // Controller side.
    modport slave (
        input  dec_valid, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2,
               dec_rd, dec_regwrite, dec_is_load, branch_taken_e, mem_wait,
        output stall_f, stall_d, stall_all, flush_d, flush_e,
               fwd_a_e, fwd_b_e, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/hazard_ctrl_fwd_sel.sv
// Operand forward-source selector: youngest non-load producer of rs among M1..Mk, W.
module fwd_sel
    import hazard_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int MEM_LAT = 1,
    parameter int FWD_W   = $clog2(MEM_LAT + 2)
) (
    input  logic [REG_AW-1:0] rs,
    input  logic              use_rs,
    input  stage_info_t       src [MEM_LAT+1],  // [0]=M1 .. [MEM_LAT-1]=Mk, [MEM_LAT]=W
    output logic [FWD_W-1:0]  sel
);

    logic hit;

    // Priority scan from youngest (M1) to oldest (W); loads still in M carry no data yet.
    always_comb begin
        sel = FWD_W'(FWD_RF);
        hit = 1'b0;
        if (use_rs && (rs != '0)) begin
            for (int i = 0; i <= MEM_LAT; i++) begin
                if (!hit && src[i].valid && src[i].regwrite && (src[i].rd != '0) &&
                    (src[i].rd == RD_MAX_W'(rs)) && !(src[i].is_load && (i < MEM_LAT))) begin
                    sel = FWD_W'(i + 1);
                    hit = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for an in-order pipeline with MEM_LAT memory stages.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 16
) (
    input logic          clk,
    input logic          rst,
    hazard_ctrl_if.slave bus
);

    localparam int FWD_W = $clog2(MEM_LAT + 2);
    localparam int NSTG  = MEM_LAT + 2;  // [0]=E, [1..MEM_LAT]=M1..Mk, [NSTG-1]=W

    stage_info_t       stg_q [NSTG];
    stage_info_t       stg_d [NSTG];
    logic [REG_AW-1:0] e_rs1_q, e_rs1_d, e_rs2_q, e_rs2_d;
    logic              e_use_rs1_q, e_use_rs1_d, e_use_rs2_q, e_use_rs2_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    stage_info_t       fwd_src [MEM_LAT+1];
    logic [FWD_W-1:0]  fwd_a_raw, fwd_b_raw;
    logic              lu;
    logic              stall_f, stall_d, stall_all, flush_d, flush_e;

    // Forward candidates are every stage downstream of E.
    always_comb begin
        for (int i = 0; i <= MEM_LAT; i++) begin
            fwd_src[i] = stg_q[i+1];
        end
    end

    fwd_sel #(.REG_AW(REG_AW), .MEM_LAT(MEM_LAT), .FWD_W(FWD_W)) u_fwd_a (
        .rs     (e_rs1_q),
        .use_rs (e_use_rs1_q),
        .src    (fwd_src),
        .sel    (fwd_a_raw)
    );

    fwd_sel #(.REG_AW(REG_AW), .MEM_LAT(MEM_LAT), .FWD_W(FWD_W)) u_fwd_b (
        .rs     (e_rs2_q),
        .use_rs (e_use_rs2_q),
        .src    (fwd_src),
        .sel    (fwd_b_raw)
    );

    // Load-use: decode reads a register a load in E..M(k-1) has not yet delivered.
    always_comb begin
        lu = 1'b0;
        for (int i = 0; i < MEM_LAT; i++) begin
            if (stg_q[i].valid && stg_q[i].is_load) begin
                if (bus.dec_use_rs1 && (bus.dec_rs1 != '0) &&
                    (stg_q[i].rd == RD_MAX_W'(bus.dec_rs1))) lu = 1'b1;
                if (bus.dec_use_rs2 && (bus.dec_rs2 != '0) &&
                    (stg_q[i].rd == RD_MAX_W'(bus.dec_rs2))) lu = 1'b1;
            end
        end
        if (!bus.dec_valid) lu = 1'b0;
    end

    // Control outputs: reset, then memory wait, then taken branch, then load-use.
    always_comb begin
        stall_f   = 1'b0;
        stall_d   = 1'b0;
        stall_all = 1'b0;
        flush_d   = 1'b0;
        flush_e   = 1'b0;
        if (rst) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (bus.mem_wait) begin
            stall_all = 1'b1;
            stall_f   = 1'b1;
            stall_d   = 1'b1;
        end else if (bus.branch_taken_e) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (lu) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    assign bus.stall_f   = stall_f;
    assign bus.stall_d   = stall_d;
    assign bus.stall_all = stall_all;
    assign bus.flush_d   = flush_d;
    assign bus.flush_e   = flush_e;
    assign bus.fwd_a_e   = rst ? '0 : fwd_a_raw;
    assign bus.fwd_b_e   = rst ? '0 : fwd_b_raw;
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;

    // Next state: shift the stage records unless frozen; saturating event counters.
    always_comb begin
        stg_d       = stg_q;
        e_rs1_d     = e_rs1_q;
        e_rs2_d     = e_rs2_q;
        e_use_rs1_d = e_use_rs1_q;
        e_use_rs2_d = e_use_rs2_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (!bus.mem_wait) begin
            for (int i = 1; i < NSTG; i++) begin
                stg_d[i] = stg_q[i-1];
            end
            if (flush_e) begin
                stg_d[0]    = '0;
                e_rs1_d     = '0;
                e_rs2_d     = '0;
                e_use_rs1_d = 1'b0;
                e_use_rs2_d = 1'b0;
            end else begin
                stg_d[0].valid    = bus.dec_valid;
                stg_d[0].rd       = RD_MAX_W'(bus.dec_rd);
                stg_d[0].regwrite = bus.dec_regwrite;
                stg_d[0].is_load  = bus.dec_is_load;
                e_rs1_d           = bus.dec_rs1;
                e_rs2_d           = bus.dec_rs2;
                e_use_rs1_d       = bus.dec_use_rs1;
                e_use_rs2_d       = bus.dec_use_rs2;
            end
        end

        if (stall_d && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (bus.branch_taken_e && !bus.mem_wait && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // State register with synchronous reset discarding all in-flight tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NSTG; i++) begin
                stg_q[i] <= '0;
            end
            e_rs1_q     <= '0;
            e_rs2_q     <= '0;
            e_use_rs1_q <= 1'b0;
            e_use_rs2_q <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stg_q       <= stg_d;
            e_rs1_q     <= e_rs1_d;
            e_rs2_q     <= e_rs2_d;
            e_use_rs1_q <= e_use_rs1_d;
            e_use_rs2_q <= e_use_rs2_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (k=1 with 16-bit counters, k=2 with 4-bit
// counters) share one stimulus stream and are compared every cycle against an
// instruction-list reference model.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       dec_valid, dec_use_rs1, dec_use_rs2, dec_regwrite, dec_is_load;
    logic [4:0] dec_rs1, dec_rs2, dec_rd;
    logic       branch_taken_e, mem_wait;

    hazard_ctrl_if #(.REG_AW(5), .MEM_LAT(1), .CNT_W(16)) if0 ();
    hazard_ctrl_if #(.REG_AW(5), .MEM_LAT(2), .CNT_W(4))  if1 ();

    assign if0.dec_valid      = dec_valid;
    assign if0.dec_rs1        = dec_rs1;
    assign if0.dec_rs2        = dec_rs2;
    assign if0.dec_use_rs1    = dec_use_rs1;
    assign if0.dec_use_rs2    = dec_use_rs2;
    assign if0.dec_rd         = dec_rd;
    assign if0.dec_regwrite   = dec_regwrite;
    assign if0.dec_is_load    = dec_is_load;
    assign if0.branch_taken_e = branch_taken_e;
    assign if0.mem_wait       = mem_wait;
    assign if1.dec_valid      = dec_valid;
    assign if1.dec_rs1        = dec_rs1;
    assign if1.dec_rs2        = dec_rs2;
    assign if1.dec_use_rs1    = dec_use_rs1;
    assign if1.dec_use_rs2    = dec_use_rs2;
    assign if1.dec_rd         = dec_rd;
    assign if1.dec_regwrite   = dec_regwrite;
    assign if1.dec_is_load    = dec_is_load;
    assign if1.branch_taken_e = branch_taken_e;
    assign if1.mem_wait       = mem_wait;

    hazard_ctrl #(.REG_AW(5), .MEM_LAT(1), .CNT_W(16)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    hazard_ctrl #(.REG_AW(5), .MEM_LAT(2), .CNT_W(4))  dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each in-flight instruction is a record with its stage position:
    // 0 = E, 1..k = M1..Mk, k+1 = W. Bubbles are simply absent.
    typedef struct {
        int rd;
        bit rw;
        bit ld;
        int rs1;
        int rs2;
        bit u1;
        bit u2;
        int pos;
    } rec_t;
    typedef rec_t rq_t[$];

    typedef struct {
        int stall_f;
        int stall_d;
        int stall_all;
        int flush_d;
        int flush_e;
        int fwd_a;
        int fwd_b;
    } exp_t;

    rq_t  mq0, mq1;
    int   cs0 = 0, cf0 = 0, cs1 = 0, cf1 = 0;
    exp_t e0, e1;

    // Youngest older instruction writing rs whose value exists (non-load, or load in W).
    function automatic int m_fwd(input rq_t q, input int k, input int rs, input bit use_r);
        int best = 0;
        int bp   = 1000;
        if (!use_r || rs == 0) return 0;
        foreach (q[i]) begin
            if (q[i].pos >= 1 && q[i].pos < bp && q[i].rw && q[i].rd == rs &&
                !(q[i].ld && q[i].pos <= k)) begin
                best = q[i].pos;
                bp   = q[i].pos;
            end
        end
        return best;
    endfunction

    function automatic exp_t m_out(input rq_t q, input int k);
        exp_t e;
        bit   lu = 0;
        e = '{default: 0};
        foreach (q[i]) begin
            if (q[i].pos == 0) begin
                e.fwd_a = m_fwd(q, k, q[i].rs1, q[i].u1);
                e.fwd_b = m_fwd(q, k, q[i].rs2, q[i].u2);
            end
            if (dec_valid && q[i].ld && q[i].pos < k &&
                ((dec_use_rs1 && dec_rs1 != 0 && q[i].rd == int'(dec_rs1)) ||
                 (dec_use_rs2 && dec_rs2 != 0 && q[i].rd == int'(dec_rs2))))
                lu = 1;
        end
        if (rst) begin
            e = '{default: 0};
            e.flush_d = 1;
            e.flush_e = 1;
        end else if (mem_wait) begin
            e.stall_all = 1;
            e.stall_f   = 1;
            e.stall_d   = 1;
        end else if (branch_taken_e) begin
            e.flush_d = 1;
            e.flush_e = 1;
        end else if (lu) begin
            e.stall_f = 1;
            e.stall_d = 1;
            e.flush_e = 1;
        end
        return e;
    endfunction

    function automatic rq_t m_adv(input rq_t q, input int k, input int fl_e);
        rq_t  n;
        rec_t r;
        foreach (q[i]) begin
            r = q[i];
            r.pos++;
            if (r.pos <= k + 1) n.push_back(r);
        end
        if (fl_e == 0 && dec_valid) begin
            r.rd  = int'(dec_rd);
            r.rw  = dec_regwrite;
            r.ld  = dec_is_load;
            r.rs1 = int'(dec_rs1);
            r.rs2 = int'(dec_rs2);
            r.u1  = dec_use_rs1;
            r.u2  = dec_use_rs2;
            r.pos = 0;
            n.push_back(r);
        end
        return n;
    endfunction

    // Compare on the falling edge, then advance the model to the next rising edge.
    always @(negedge clk) begin
        e0 = m_out(mq0, 1);
        e1 = m_out(mq1, 2);
        chk("k1 stall_f",   int'(if0.stall_f),   e0.stall_f);
        chk("k1 stall_d",   int'(if0.stall_d),   e0.stall_d);
        chk("k1 stall_all", int'(if0.stall_all), e0.stall_all);
        chk("k1 flush_d",   int'(if0.flush_d),   e0.flush_d);
        chk("k1 flush_e",   int'(if0.flush_e),   e0.flush_e);
        chk("k1 fwd_a",     int'(if0.fwd_a_e),   e0.fwd_a);
        chk("k1 fwd_b",     int'(if0.fwd_b_e),   e0.fwd_b);
        chk("k1 stall_cnt", int'(if0.stall_cnt), cs0);
        chk("k1 flush_cnt", int'(if0.flush_cnt), cf0);
        chk("k2 stall_f",   int'(if1.stall_f),   e1.stall_f);
        chk("k2 stall_d",   int'(if1.stall_d),   e1.stall_d);
        chk("k2 stall_all", int'(if1.stall_all), e1.stall_all);
        chk("k2 flush_d",   int'(if1.flush_d),   e1.flush_d);
        chk("k2 flush_e",   int'(if1.flush_e),   e1.flush_e);
        chk("k2 fwd_a",     int'(if1.fwd_a_e),   e1.fwd_a);
        chk("k2 fwd_b",     int'(if1.fwd_b_e),   e1.fwd_b);
        chk("k2 stall_cnt", int'(if1.stall_cnt), cs1);
        chk("k2 flush_cnt", int'(if1.flush_cnt), cf1);
        if (rst) begin
            mq0.delete();
            mq1.delete();
            cs0 = 0; cf0 = 0; cs1 = 0; cf1 = 0;
        end else begin
            if (e0.stall_d == 1 && cs0 < 65535) cs0++;
            if (e1.stall_d == 1 && cs1 < 15)    cs1++;
            if (branch_taken_e && !mem_wait) begin
                if (cf0 < 65535) cf0++;
                if (cf1 < 15)    cf1++;
            end
            if (!mem_wait) begin
                mq0 = m_adv(mq0, 1, e0.flush_e);
                mq1 = m_adv(mq1, 2, e1.flush_e);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dec(input bit v, input int rd, input bit rw, input bit ld,
                       input int rs1, input bit u1, input int rs2, input bit u2);
        dec_valid    = v;
        dec_rd       = 5'(rd);
        dec_regwrite = rw;
        dec_is_load  = ld;
        dec_rs1      = 5'(rs1);
        dec_use_rs1  = u1;
        dec_rs2      = 5'(rs2);
        dec_use_rs2  = u2;
    endtask

    task automatic idle();
        dec(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic drain();
        idle();
        branch_taken_e = 0;
        mem_wait       = 0;
        repeat (4) tick();
    endtask

    task automatic rand_cycle();
        bit v;
        v = ($urandom_range(0, 4) != 0);
        if (v) dec(1, $urandom_range(0, 7), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                   $urandom_range(0, 7), $urandom_range(0, 3) != 0,
                   $urandom_range(0, 7), $urandom_range(0, 1) != 0);
        else   idle();
        branch_taken_e = ($urandom_range(0, 9) == 0);
        mem_wait       = ($urandom_range(0, 7) == 0);
        tick();
    endtask

    int base, n;

    initial begin
        rst = 1;
        branch_taken_e = 0;
        mem_wait = 0;
        idle();
        repeat (2) tick();
        #1;
        chk("rst k1 flush_d", int'(if0.flush_d), 1);
        chk("rst k1 flush_e", int'(if0.flush_e), 1);
        chk("rst k2 stall_f", int'(if1.stall_f), 0);
        rst = 0;
        tick();
        chk("post-rst k1 stall_cnt", int'(if0.stall_cnt), 0);
        chk("post-rst k1 flush_d", int'(if0.flush_d), 0);

        // ALU producer in E, consumer decoded next: forward from M1.
        drain();
        dec(1, 5, 1, 0, 1, 1, 2, 1); tick();
        dec(1, 8, 1, 0, 5, 1, 3, 1); #1;
        chk("t1 k1 no stall", int'(if0.stall_d), 0);
        tick(); #1;
        chk("t1 k1 fwd_a M1", int'(if0.fwd_a_e), 1);
        chk("t1 k1 fwd_b RF", int'(if0.fwd_b_e), 0);
        chk("t1 k2 fwd_a M1", int'(if1.fwd_a_e), 1);

        // Load followed by dependent: one bubble for k=1, then forward from W.
        drain();
        dec(1, 6, 1, 1, 2, 1, 0, 0); tick();
        dec(1, 7, 1, 0, 6, 1, 1, 1); #1;
        chk("t2 k1 stall_f", int'(if0.stall_f), 1);
        chk("t2 k1 stall_d", int'(if0.stall_d), 1);
        chk("t2 k1 flush_e", int'(if0.flush_e), 1);
        chk("t2 k1 flush_d", int'(if0.flush_d), 0);
        tick(); #1;
        chk("t2 k1 stall released", int'(if0.stall_d), 0);
        chk("t2 k2 still stalled", int'(if1.stall_d), 1);
        tick(); #1;
        chk("t2 k1 fwd_a W", int'(if0.fwd_a_e), 2);
        chk("t2 k2 stall released", int'(if1.stall_d), 0);

        // k=2: load-use costs exactly two stall cycles.
        drain();
        base = int'(if1.stall_cnt);
        dec(1, 6, 1, 1, 2, 1, 0, 0); tick();
        dec(1, 7, 1, 0, 6, 1, 1, 1);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (if1.stall_d) begin
                n++;
                tick();
            end else begin
                break;
            end
        end
        chk("t3 k2 stall cycles", n, 2);
        chk("t3 k2 stall_cnt delta", int'(if1.stall_cnt) - base, 2);
        tick(); #1;
        chk("t3 k2 fwd_a W", int'(if1.fwd_a_e), 3);

        // Taken branch beats a load-use match.
        drain();
        base = int'(if0.flush_cnt);
        dec(1, 6, 1, 1, 2, 1, 0, 0); tick();
        dec(1, 7, 1, 0, 6, 1, 1, 1);
        branch_taken_e = 1; #1;
        chk("t4 k1 flush_d", int'(if0.flush_d), 1);
        chk("t4 k1 flush_e", int'(if0.flush_e), 1);
        chk("t4 k1 stall_f", int'(if0.stall_f), 0);
        tick();
        branch_taken_e = 0; #1;
        chk("t4 k1 flush_cnt delta", int'(if0.flush_cnt) - base, 1);

        // Memory wait freezes state and forwarding for three cycles.
        drain();
        dec(1, 5, 1, 0, 1, 1, 2, 1); tick();
        dec(1, 8, 1, 0, 5, 1, 3, 1); tick(); #1;
        chk("t5 k1 fwd_a before wait", int'(if0.fwd_a_e), 1);
        mem_wait = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t5 k1 stall_all", int'(if0.stall_all), 1);
            chk("t5 k1 fwd_a frozen", int'(if0.fwd_a_e), 1);
            tick();
        end
        mem_wait = 0; #1;
        chk("t5 k1 stall_all off", int'(if0.stall_all), 0);
        chk("t5 k1 fwd_a after wait", int'(if0.fwd_a_e), 1);
        tick(); #1;
        chk("t5 k1 fwd_a advanced", int'(if0.fwd_a_e), 2);

        // Writers of x0 never forward or stall.
        drain();
        dec(1, 0, 1, 0, 1, 1, 2, 1); tick();
        dec(1, 0, 1, 1, 3, 1, 0, 0); tick();
        dec(1, 9, 1, 0, 0, 1, 0, 1); #1;
        chk("t6 k1 x0 no stall", int'(if0.stall_d), 0);
        tick(); #1;
        chk("t6 k1 x0 fwd_a", int'(if0.fwd_a_e), 0);
        chk("t6 k1 x0 fwd_b", int'(if0.fwd_b_e), 0);

        // Random traffic; the 4-bit counter must end pinned at all-ones.
        for (int i = 0; i < 300; i++) rand_cycle();
        idle();
        branch_taken_e = 0;
        mem_wait = 0; #1;
        chk("sat k2 stall_cnt", int'(if1.stall_cnt), 15);

        // Reset in the middle of traffic discards the in-flight producer.
        dec(1, 5, 1, 0, 1, 1, 2, 1); tick();
        dec(1, 8, 1, 0, 5, 1, 3, 1);
        rst = 1; #1;
        chk("t7 k1 rst flush_d", int'(if0.flush_d), 1);
        chk("t7 k1 rst stall_d", int'(if0.stall_d), 0);
        chk("t7 k1 rst fwd_a", int'(if0.fwd_a_e), 0);
        tick();
        chk("t7 k1 stall_cnt cleared", int'(if0.stall_cnt), 0);
        chk("t7 k2 stall_cnt cleared", int'(if1.stall_cnt), 0);
        chk("t7 k1 flush_cnt cleared", int'(if0.flush_cnt), 0);
        rst = 0;
        tick(); #1;
        chk("t7 k1 producer discarded", int'(if0.fwd_a_e), 0);

        for (int i = 0; i < 200; i++) rand_cycle();
        idle();
        branch_taken_e = 0;
        mem_wait = 0;
        tick();
        @(negedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
